profile_ci_multi: RTL

Parameterised successor to the single-ID profiling custom instruction. Provides NR_COUNTERS event counters of COUNTER_WIDTH bits: cycle, stall, bus-idle, active, plus external events. Adds per-counter enable/disable/clear masks, sticky overflow flags, selectable wrap or saturate mode, and an atomic snapshot bank. Sits on the CPU custom-instruction port beside the other CI blocks and answers only when ciN equals customId.

---
 rtl/profile_ci_multi_if.sv | 13 +
 rtl/profile_ci_multi.sv | 126 ++++++++++++
 2 files changed

// File: rtl/profile_ci_multi_if.sv
// Custom-instruction port bundle: CPU drives start/ciN/operands, the CI block
// answers with done/result in the same cycle.
interface profile_ci_multi_if;
    logic        start;
    logic [7:0]  ciN;
    logic [31:0] valueA;
    logic [31:0] valueB;
    logic        done;
    logic [31:0] result;

    modport master (output start, ciN, valueA, valueB, input done, result);
    modport slave  (input start, ciN, valueA, valueB, output done, result);
endinterface

// File: rtl/profile_ci_multi.sv
// Multi-counter profiling custom instruction: masked enable/disable/clear,
// sticky overflow, wrap or saturate, and an atomic snapshot bank.
module profile_ci_multi #(
    parameter logic [7:0] customId      = 8'h00,
    parameter int         NR_COUNTERS   = 8,
    parameter int         COUNTER_WIDTH = 32,
    parameter int         SATURATE      = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    profile_ci_multi_if.slave      ci,
    input  logic                   stall,
    input  logic                   busIdle,
    input  logic [NR_COUNTERS-5:0] extEvents
);

    localparam logic [2:0] CMD_READ    = 3'd0;
    localparam logic [2:0] CMD_ENABLE  = 3'd1;
    localparam logic [2:0] CMD_DISABLE = 3'd2;
    localparam logic [2:0] CMD_CLEAR   = 3'd3;
    localparam logic [2:0] CMD_SNAP    = 3'd4;
    localparam logic [2:0] CMD_RSHADOW = 3'd5;
    localparam logic [2:0] CMD_STATUS  = 3'd6;

    localparam logic [COUNTER_WIDTH-1:0] ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

    logic [COUNTER_WIDTH-1:0] ctr_q    [NR_COUNTERS];
    logic [COUNTER_WIDTH-1:0] ctr_d    [NR_COUNTERS];
    logic [COUNTER_WIDTH-1:0] shadow_q [NR_COUNTERS];
    logic [COUNTER_WIDTH-1:0] shadow_d [NR_COUNTERS];
    logic [NR_COUNTERS-1:0]   en_q, en_d;
    logic [NR_COUNTERS-1:0]   ovf_q, ovf_d;
    logic [NR_COUNTERS-1:0]   src;
    logic [NR_COUNTERS-1:0]   mask;
    logic [2:0]               cmd;
    logic                     sel;
    logic [31:0]              rd_ctr, rd_shd, status, result_c;
    logic                     unused_bits;

    function automatic logic [COUNTER_WIDTH-1:0] next_count(input logic [COUNTER_WIDTH-1:0] v);
        if (&v) return (SATURATE != 0) ? v : '0;
        return v + ONE;
    endfunction

    assign sel         = ci.start && (ci.ciN == customId);
    assign cmd         = ci.valueB[2:0];
    assign mask        = ci.valueA[NR_COUNTERS-1:0];
    assign unused_bits = &{1'b0, ci.valueA[31:NR_COUNTERS], ci.valueB[31:3]};

    always_comb begin
        src                  = '0;
        src[0]               = 1'b1;
        src[1]               = stall;
        src[2]               = busIdle;
        src[3]               = !stall;
        src[NR_COUNTERS-1:4] = extEvents;
    end

    // Increment first, then let a same-edge CLEAR override it.
    always_comb begin
        en_d     = en_q;
        ovf_d    = ovf_q;
        ctr_d    = ctr_q;
        shadow_d = shadow_q;
        for (int i = 0; i < NR_COUNTERS; i++) begin
            if (en_q[i] && src[i]) begin
                ctr_d[i] = next_count(ctr_q[i]);
                if (&ctr_q[i]) ovf_d[i] = 1'b1;
            end
            if (sel && cmd == CMD_CLEAR && mask[i]) begin
                ctr_d[i] = '0;
                ovf_d[i] = 1'b0;
            end
            if (sel && cmd == CMD_SNAP) shadow_d[i] = ctr_q[i];
        end
        if (sel && cmd == CMD_ENABLE)  en_d = en_q | mask;
        if (sel && cmd == CMD_DISABLE) en_d = en_q & ~mask;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NR_COUNTERS; i++) begin
                ctr_q[i]    <= '0;
                shadow_q[i] <= '0;
            end
            en_q  <= '0;
            ovf_q <= '0;
        end else begin
            ctr_q    <= ctr_d;
            shadow_q <= shadow_d;
            en_q     <= en_d;
            ovf_q    <= ovf_d;
        end
    end

    // Indices past the last counter fall through to zero.
    always_comb begin
        rd_ctr = '0;
        rd_shd = '0;
        for (int i = 0; i < NR_COUNTERS; i++) begin
            if (ci.valueA[3:0] == 4'(i)) begin
                rd_ctr[COUNTER_WIDTH-1:0] = ctr_q[i];
                rd_shd[COUNTER_WIDTH-1:0] = shadow_q[i];
            end
        end
        status                   = '0;
        status[NR_COUNTERS-1:0]  = en_q;
        status[16 +: NR_COUNTERS] = ovf_q;
    end

    always_comb begin
        result_c = '0;
        if (sel) begin
            case (cmd)
                CMD_READ:    result_c = rd_ctr;
                CMD_RSHADOW: result_c = rd_shd;
                CMD_STATUS:  result_c = status;
                default:     result_c = '0;
            endcase
        end
    end

    assign ci.done   = sel;
    assign ci.result = result_c;

endmodule
